soft_deinterleaver_pp: RTL and testbench

Parametrised 802.11a block deinterleaver for all four modulations (BPSK/QPSK/16-QAM/64-QAM), carrying SOFT_W-bit soft decisions per coded bit. It sits between the demapper and the Viterbi decoder. Two ping-pong symbol banks let one OFDM symbol be written while the previous one is read, so input streams continuously. Both sides use a valid/ready handshake, so the decoder can apply backpressure.

---
 rtl/soft_deinterleaver_pp.sv | 176 +++++++++++++++++
 tb/tb_soft_deinterleaver_pp.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/soft_deinterleaver_pp.sv
// 802.11a block deinterleaver for BPSK..64-QAM soft samples with ping-pong symbol banks.
// Samples are written in permuted order and read back sequentially; both sides use valid/ready.
module soft_deinterleaver_pp #(
   parameter int unsigned SOFT_W    = 1,
   parameter int unsigned NCBPS_MAX = 288,
   parameter int unsigned ADDR_W    = 9
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [SOFT_W-1:0] inputData,
   input  logic              inputValid,
   output logic              inputReady,
   input  logic [1:0]        mode,
   output logic [SOFT_W-1:0] outputData,
   output logic              outputValid,
   input  logic              outputReady,
   output logic              outputLast
);

   localparam int unsigned ROW_W = 4;
   localparam int unsigned COL_W = 5;
   localparam int unsigned RCW   = ROW_W + COL_W;

   // NCBPS = 16 * cols; the permutation rotates each group of `step` samples.
   function automatic logic [1:0] stepOf(input logic [1:0] m);
      case (m)
         2'd2:    return 2'd2;
         2'd3:    return 2'd3;
         default: return 2'd1;
      endcase
   endfunction

   function automatic logic [COL_W-1:0] colsOf(input logic [1:0] m);
      case (m)
         2'd0:    return 5'd3;
         2'd1:    return 5'd6;
         2'd2:    return 5'd12;
         default: return 5'd18;
      endcase
   endfunction

   logic [SOFT_W-1:0] mem [2][NCBPS_MAX];
   logic [1:0]        bankMode [2];
   logic [1:0]        bankFull;
   logic [1:0]        fullNext;

   logic              wrBank;
   logic              wrBankNext;
   logic              wrActive;
   logic [1:0]        curMode;
   logic [ROW_W-1:0]  wrRow;
   logic [COL_W-1:0]  wrCol;
   logic [1:0]        wrSub;
   logic [1:0]        wrRot;

   logic [1:0]        wrMode;
   logic [1:0]        wrStep;
   logic [COL_W-1:0]  wrCols;
   logic [2:0]        rotSum;
   logic [2:0]        rotSub;
   logic [COL_W-1:0]  wrColPerm;
   logic [ADDR_W-1:0] wrAddr;
   logic              wrAccept;
   logic              wrColEnd;
   logic              wrEnd;

   logic              rdBank;
   logic [ADDR_W-1:0] rdCnt;
   logic [COL_W-1:0]  rdCols;
   logic              rdEnd;
   logic              rdLoad;
   logic              outDone;
   logic              readyNext;

   // Write address: k = 16 * (col with rotated sub-position) + row, all from counters.
   always_comb begin
      wrMode    = wrActive ? curMode : mode;
      wrStep    = stepOf(wrMode);
      wrCols    = colsOf(wrMode);
      rotSum    = 3'(wrSub) + 3'(wrRot);
      rotSub    = (rotSum >= 3'(wrStep)) ? rotSum - 3'(wrStep) : rotSum;
      wrColPerm = wrCol - COL_W'(wrSub) + COL_W'(rotSub);
      wrAddr    = ADDR_W'({wrColPerm, 4'b0000}) + ADDR_W'(wrRow);
      wrAccept  = inputValid && inputReady;
      wrColEnd  = (wrCol == wrCols - 5'd1);
      wrEnd     = (wrRow == 4'd15) && wrColEnd;
   end

   // The bank to free is the one behind rdBank: rdBank moves on once its last sample is loaded.
   always_comb begin
      rdCols     = colsOf(bankMode[rdBank]);
      rdEnd      = (rdCnt == ADDR_W'({rdCols, 4'b0000}) - ADDR_W'(1));
      rdLoad     = bankFull[rdBank] && (!outputValid || outputReady);
      outDone    = outputValid && outputReady && outputLast;
      fullNext   = bankFull;
      if (outDone)
         fullNext[~rdBank] = 1'b0;
      if (wrAccept && wrEnd)
         fullNext[wrBank] = 1'b1;
      wrBankNext = wrBank ^ (wrAccept && wrEnd);
      readyNext  = !fullNext[wrBankNext];
   end

   always_ff @(posedge clock) begin
      if (wrAccept)
         mem[wrBank][wrAddr] <= inputData;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         bankFull    <= 2'b00;
         bankMode[0] <= 2'd0;
         bankMode[1] <= 2'd0;
         wrBank      <= 1'b0;
         wrActive    <= 1'b0;
         curMode     <= 2'd0;
         wrRow       <= '0;
         wrCol       <= '0;
         wrSub       <= 2'd0;
         wrRot       <= 2'd0;
         inputReady  <= 1'b0;
      end else begin
         bankFull   <= fullNext;
         wrBank     <= wrBankNext;
         inputReady <= readyNext;
         if (wrAccept) begin
            if (!wrActive) begin
               bankMode[wrBank] <= mode;
               curMode          <= mode;
            end
            if (wrEnd) begin
               wrActive <= 1'b0;
               wrRow    <= '0;
               wrCol    <= '0;
               wrSub    <= 2'd0;
               wrRot    <= 2'd0;
            end else begin
               wrActive <= 1'b1;
               wrSub    <= (wrSub == wrStep - 2'd1) ? 2'd0 : wrSub + 2'd1;
               if (wrColEnd) begin
                  wrCol <= '0;
                  wrRow <= wrRow + 4'd1;
                  wrRot <= (wrRot == wrStep - 2'd1) ? 2'd0 : wrRot + 2'd1;
               end else begin
                  wrCol <= wrCol + 5'd1;
               end
            end
         end
      end
   end

   // Output register reloads on the same edge it hands off, so full banks stream gap-free.
   always_ff @(posedge clock) begin
      if (reset) begin
         rdBank      <= 1'b0;
         rdCnt       <= '0;
         outputData  <= '0;
         outputValid <= 1'b0;
         outputLast  <= 1'b0;
      end else if (rdLoad) begin
         outputData  <= mem[rdBank][rdCnt];
         outputLast  <= rdEnd;
         outputValid <= 1'b1;
         rdCnt       <= rdEnd ? '0 : rdCnt + ADDR_W'(1);
         if (rdEnd)
            rdBank <= ~rdBank;
      end else if (outputReady) begin
         outputValid <= 1'b0;
         outputLast  <= 1'b0;
      end
   end

   logic unusedRcw;
   assign unusedRcw = (RCW > ADDR_W) ? 1'b0 : 1'b1;

endmodule

// File: tb/tb_soft_deinterleaver_pp.sv
// Randomized bench for soft_deinterleaver_pp against a direct-formula interleaver model.
module tb_soft_deinterleaver_pp;

   logic       clock = 1'b0;
   logic       reset;
   logic [3:0] inputData;
   logic       inputValid;
   logic       inputReady;
   logic [1:0] mode;
   logic [3:0] outputData;
   logic       outputValid;
   logic       outputReady;
   logic       outputLast;

   soft_deinterleaver_pp #(.SOFT_W(4), .NCBPS_MAX(288), .ADDR_W(9)) dut (
      .clock      (clock),
      .reset      (reset),
      .inputData  (inputData),
      .inputValid (inputValid),
      .inputReady (inputReady),
      .mode       (mode),
      .outputData (outputData),
      .outputValid(outputValid),
      .outputReady(outputReady),
      .outputLast (outputLast)
   );

   always #5 clock = ~clock;

   int nTests = 0;
   int nFail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nTests++;
      if (got !== exp) begin
         nFail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int nOf(input int m);
      case (m)
         0: return 48;
         1: return 96;
         2: return 192;
         default: return 288;
      endcase
   endfunction

   function automatic int sOf(input int m);
      return (m == 3) ? 3 : (m == 2) ? 2 : 1;
   endfunction

   // Interleaver write position of input sample j, straight from the two permutation formulas.
   function automatic int kOf(input int j, input int n, input int s);
      int i;
      i = s * (j / s) + ((j + (16 * j) / n) % s);
      return 16 * i - (n - 1) * ((16 * i) / n);
   endfunction

   logic [3:0] sbD[$];
   bit         sbL[$];
   int         lenQ[$];
   logic [3:0] outLog[$];
   int         pending = 0;
   int         inCount = 0;
   int         xferCount = 0;
   int         readyPct = 100;
   bit         gapEn = 0;
   bit         inSym = 0;
   bit         expectNext = 0;
   bit         prevHold = 0;
   logic [3:0] prevData;
   logic       prevLast;
   bit         rstGuard = 1;

   always @(posedge clock) begin
      #1;
      outputReady = ($urandom_range(99) < readyPct);
   end

   // Monitor: scoreboard, hold stability, gap-free streaming and bank-occupancy stall rule.
   always @(negedge clock) begin
      if (reset) begin
         rstGuard   = 1;
         prevHold   = 0;
         inSym      = 0;
         expectNext = 0;
      end else if (rstGuard) begin
         rstGuard = 0;
      end else begin
         check("inputReady", 32'(inputReady), 32'(pending < 2));
         if (prevHold) begin
            check("holdValid", 32'(outputValid), 1);
            check("holdData", 32'(outputData), 32'(prevData));
            check("holdLast", 32'(outputLast), 32'(prevLast));
         end
         if (expectNext)
            check("gapBoundary", 32'(outputValid), 1);
         if (gapEn && inSym)
            check("gapWithin", 32'(outputValid), 1);
         expectNext = gapEn && outputValid && outputReady && outputLast && (pending >= 2);
         if (outputValid && outputReady) begin
            xferCount++;
            outLog.push_back(outputData);
            if (sbD.size() == 0) begin
               check("unexpectedOut", 1, 0);
            end else begin
               check("outData", 32'(outputData), 32'(sbD.pop_front()));
               check("outLast", 32'(outputLast), 32'(sbL.pop_front()));
            end
            inSym = !outputLast;
            if (outputLast && pending > 0)
               pending--;
         end
         if (inputValid && inputReady) begin
            inCount++;
            if (lenQ.size() > 0 && inCount == lenQ[0]) begin
               pending++;
               void'(lenQ.pop_front());
               inCount = 0;
            end
         end
         prevHold = outputValid && !outputReady;
         prevData = outputData;
         prevLast = outputLast;
      end
   end

   // Called just after a rising edge; returns just after the edge that took the last sample.
   task automatic sendSymbol(input int m, input int glitchAt, input int altMode,
                             input int validPct, input bit numbered, input int abortAt);
      int n;
      int s;
      int waited;
      bit acc;
      logic [3:0] d[288];
      logic [3:0] e[288];
      n = nOf(m);
      s = sOf(m);
      for (int j = 0; j < n; j++)
         d[j] = numbered ? 4'(j) : 4'($urandom);
      for (int j = 0; j < n; j++)
         e[kOf(j, n, s)] = d[j];
      if (abortAt >= n) begin
         for (int p = 0; p < n; p++) begin
            sbD.push_back(e[p]);
            sbL.push_back(p == n - 1);
         end
      end
      lenQ.push_back(n);
      for (int j = 0; j < n && j < abortAt; j++) begin
         acc    = 0;
         waited = 0;
         while (!acc) begin
            inputData  = d[j];
            mode       = (j >= glitchAt) ? 2'(altMode) : 2'(m);
            inputValid = ($urandom_range(99) < validPct);
            @(negedge clock);
            acc = inputValid && inputReady;
            @(posedge clock);
            #1;
            waited++;
            if (!acc && waited > 3000) begin
               check("inputTimeout", 0, 1);
               inputValid = 0;
               return;
            end
         end
      end
      inputValid = 0;
   endtask

   task automatic waitDrain();
      int t;
      t = 0;
      do begin
         @(posedge clock);
         t++;
      end while (sbD.size() > 0 && t < 6000);
      #1;
      check("drain", 32'(sbD.size()), 0);
   endtask

   int  found;
   int  xBefore;

   initial begin
      reset      = 1;
      inputData  = 0;
      inputValid = 0;
      mode       = 0;
      outputReady = 1;
      repeat (3) @(posedge clock);
      #1;
      check("rstValid", 32'(outputValid), 0);
      check("rstLast", 32'(outputLast), 0);
      check("rstData", 32'(outputData), 0);
      check("rstReady", 32'(inputReady), 0);
      reset = 0;
      @(posedge clock);
      #1;
      check("readyAfterReset", 32'(inputReady), 1);

      // BPSK with numbered samples, ready held high
      gapEn = 1;
      outLog.delete();
      sendSymbol(0, 9999, 0, 100, 1, 9999);
      found = 0;
      for (int c = 1; c <= 4 && found == 0; c++) begin
         @(negedge clock);
         if (outputValid) found = c;
      end
      check("latencyBpsk", 32'(found != 0), 1);
      @(posedge clock);
      #1;
      waitDrain();
      check("bpskCount", 32'(outLog.size()), 48);
      check("bpskPos1", 32'(outLog[1]), 3);
      check("bpskPos2", 32'(outLog[2]), 6);
      check("bpskPos16", 32'(outLog[16]), 1);

      // 64-QAM numbered, then random data
      outLog.delete();
      sendSymbol(3, 9999, 0, 100, 1, 9999);
      waitDrain();
      check("qam64Pos16", 32'(outLog[16]), 1);
      check("qam64Pos17", 32'(outLog[17]), 2);
      sendSymbol(3, 9999, 0, 100, 0, 9999);
      waitDrain();

      // Back-to-back symbols of different modes
      sendSymbol(3, 9999, 0, 100, 0, 9999);
      sendSymbol(1, 9999, 0, 100, 0, 9999);
      sendSymbol(2, 9999, 0, 100, 0, 9999);
      sendSymbol(0, 9999, 0, 100, 0, 9999);
      waitDrain();

      // Mode changes mid-symbol must be ignored
      sendSymbol(3, 100, 0, 100, 0, 9999);
      waitDrain();

      // Random backpressure, 30% low
      gapEn    = 0;
      readyPct = 70;
      for (int q = 0; q < 8; q++)
         sendSymbol($urandom_range(3), 9999, 0, (q % 2 == 0) ? 100 : 80, 0, 9999);
      waitDrain();

      // Reset with a full bank pending and a 16-QAM symbol half written
      readyPct = 0;
      sendSymbol(3, 9999, 0, 100, 0, 9999);
      sendSymbol(2, 9999, 0, 100, 0, 150);
      reset = 1;
      sbD.delete();
      sbL.delete();
      lenQ.delete();
      pending = 0;
      inCount = 0;
      @(posedge clock);
      @(negedge clock);
      check("midRstValid", 32'(outputValid), 0);
      check("midRstLast", 32'(outputLast), 0);
      check("midRstData", 32'(outputData), 0);
      check("midRstReady", 32'(inputReady), 0);
      @(posedge clock);
      #1;
      reset    = 0;
      readyPct = 100;
      xBefore  = xferCount;
      repeat (20) @(posedge clock);
      #1;
      check("noOutAfterRst", 32'(xferCount - xBefore), 0);
      outLog.delete();
      gapEn = 1;
      sendSymbol(0, 9999, 0, 100, 1, 9999);
      waitDrain();
      check("postRstCount", 32'(outLog.size()), 48);
      check("postRstPos1", 32'(outLog[1]), 3);
      check("postRstPos16", 32'(outLog[16]), 1);

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
